// File: rtl/cla_4bit_trial2_perplexity.sv
// 4-bit carry-lookahead adder: combinational {Cout,Sum} = A + B + Cin with group P/G,
// signed-overflow flag, and a registered copy of the sum/carry for pipelined users.
module cla_4bit_trial2_perplexity (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] A,
   input  logic [3:0] B,
   input  logic       Cin,
   output logic [3:0] Sum,
   output logic       Cout,
   output logic       PG,
   output logic       GG,
   output logic       Ovf,
   output logic [3:0] Sum_q,
   output logic       Cout_q
);

   logic [3:0] p;
   logic [3:0] g;
   logic       c1;
   logic       c2;
   logic       c3;
   logic       c4;
   logic       gg;

   assign p = A ^ B;
   assign g = A & B;

   // Every carry is a flat sum of products of p/g and Cin, so no carry waits on another.
   assign c1 = g[0]
             | (p[0] & Cin);
   assign c2 = g[1]
             | (p[1] & g[0])
             | (p[1] & p[0] & Cin);
   assign c3 = g[2]
             | (p[2] & g[1])
             | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & Cin);
   assign c4 = g[3]
             | (p[3] & g[2])
             | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & Cin);

   // Group generate is c4 with the carry-in term removed (Cin forced to 0).
   assign gg = g[3]
             | (p[3] & g[2])
             | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0]);

   assign Sum  = p ^ {c3, c2, c1, Cin};
   assign Cout = c4;
   assign PG   = &p;
   assign GG   = gg;
   assign Ovf  = c3 ^ c4;

   // Reset clears only the registered copy; the combinational path ignores rst.
   always_ff @(posedge clk) begin
      if (rst) begin
         Sum_q  <= 4'b0000;
         Cout_q <= 1'b0;
      end else begin
         Sum_q  <= Sum;
         Cout_q <= Cout;
      end
   end

endmodule

// File: tb/tb_cla_4bit_trial2_perplexity.sv
// Bench for cla_4bit_trial2_perplexity: directed corner vectors plus random operands,
// compared against an integer-arithmetic reference and an expected queue for the registers.
module tb_cla_4bit_trial2_perplexity;

   logic       clk;
   logic       rst;
   logic [3:0] a;
   logic [3:0] b;
   logic       cin;
   logic [3:0] sum;
   logic       cout;
   logic       pg;
   logic       gg;
   logic       ovf;
   logic [3:0] sum_q;
   logic       cout_q;

   int total_cnt = 0;
   int bad_cnt   = 0;
   logic [4:0] exp_q[$];

   cla_4bit_trial2_perplexity dut (
      .clk    (clk),
      .rst    (rst),
      .A      (a),
      .B      (b),
      .Cin    (cin),
      .Sum    (sum),
      .Cout   (cout),
      .PG     (pg),
      .GG     (gg),
      .Ovf    (ovf),
      .Sum_q  (sum_q),
      .Cout_q (cout_q)
   );

   // clock/reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got !== exp) begin
         bad_cnt++;
         $display("FAIL %s: got=%0h expected=%0h (a=%0d b=%0d cin=%0d)", tag, got, exp, a, b, cin);
      end
   endtask

   // reference model: plain integer arithmetic
   function automatic logic [4:0] ref_total(input int x, input int y, input int c);
      int s;
      s = x + y + c;
      return s[4:0];
   endfunction

   function automatic logic ref_ovf(input int x, input int y, input int c);
      int sx;
      int sy;
      int s;
      sx = (x >= 8) ? x - 16 : x;
      sy = (y >= 8) ? y - 16 : y;
      s  = sx + sy + c;
      return (s > 7) || (s < -8);
   endfunction

   task automatic check_comb();
      int x;
      int y;
      int c;
      x = int'(a);
      y = int'(b);
      c = int'(cin);
      check("sum_cout", {27'd0, cout, sum}, {27'd0, ref_total(x, y, c)});
      check("pg", {31'd0, pg}, {31'd0, ((x ^ y) == 15)});
      check("gg", {31'd0, gg}, {31'd0, ((x + y) > 15)});
      check("ovf", {31'd0, ovf}, {31'd0, ref_ovf(x, y, c)});
   endtask

   // driver: apply at negedge, check combinational, then registered after the next edge
   task automatic apply(input logic [3:0] xa, input logic [3:0] xb, input logic xc);
      logic [4:0] exp_r;
      @(negedge clk);
      a   = xa;
      b   = xb;
      cin = xc;
      #2;
      check_comb();
      exp_q.push_back(ref_total(int'(xa), int'(xb), int'(xc)));
      @(posedge clk);
      #1;
      exp_r = exp_q.pop_front();
      check("reg", {27'd0, cout_q, sum_q}, {27'd0, exp_r});
   endtask

   initial begin
      rst = 1'b1;
      a   = 4'd5;
      b   = 4'd6;
      cin = 1'b0;

      // reset: registers clear, combinational path still live
      @(posedge clk);
      #1;
      check("rst_sum_q", {28'd0, sum_q}, 32'd0);
      check("rst_cout_q", {31'd0, cout_q}, 32'd0);
      check_comb();
      @(negedge clk);
      a   = 4'd9;
      b   = 4'd9;
      cin = 1'b1;
      @(posedge clk);
      #1;
      check("rst_hold", {27'd0, cout_q, sum_q}, 32'd0);
      check_comb();

      @(negedge clk);
      rst = 1'b0;
      apply(4'b0111, 4'b0001, 1'b0);
      check("post_rst_sum_q", {28'd0, sum_q}, 32'h8);
      check("post_rst_cout_q", {31'd0, cout_q}, 32'd0);

      // directed corners
      apply(4'b0000, 4'b0000, 1'b0);
      check("zero", {27'd0, cout, sum}, 32'h00);
      apply(4'b1111, 4'b1111, 1'b0);
      check("max_c0", {27'd0, cout, sum}, 32'h1e);
      apply(4'b1111, 4'b1111, 1'b1);
      check("max_c1", {27'd0, cout, sum}, 32'h1f);
      apply(4'b1010, 4'b0101, 1'b1);
      check("prop_chain", {27'd0, cout, sum}, 32'h10);
      check("prop_pg", {31'd0, pg}, 32'd1);
      apply(4'b1000, 4'b1000, 1'b1);
      check("wrap", {27'd0, cout, sum}, 32'h11);
      check("wrap_ovf", {31'd0, ovf}, 32'd1);
      apply(4'b1110, 4'b0011, 1'b1);
      check("mixed", {27'd0, cout, sum}, 32'h12);

      // randomized operands
      for (int i = 0; i < 40; i++) begin
         apply(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      end

      // mid-run reset clears the registered copy again
      @(negedge clk);
      rst = 1'b1;
      a   = 4'd15;
      b   = 4'd1;
      cin = 1'b0;
      @(posedge clk);
      #1;
      check("rst2_reg", {27'd0, cout_q, sum_q}, 32'd0);
      check_comb();
      @(negedge clk);
      rst = 1'b0;
      apply(4'd3, 4'd4, 1'b1);

      $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
      $finish;
   end

endmodule
